i2cm_ctrl: RTL and testbench

I2CM_CTRL -- requirements
Module: i2cm_ctrl

---
 rtl/i2cm_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_i2cm_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/i2cm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : i2cm_ctrl
//  Purpose  : I2C master bit/byte engine: START, STOP, 8-bit WRITE/READ + ack,
//             quarter-bit timing, clock stretching and arbitration detection.
//  Revision : 1.0  initial release
// ============================================================================
module i2cm_ctrl #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] presc,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd,
  input  logic [7:0]         cmd_wdata,
  input  logic               cmd_nack,
  output logic               done,
  output logic [7:0]         rdata,
  output logic               rx_nack,
  output logic               arb_lost,
  output logic               busy,
  input  logic               i2c_scl_i,
  input  logic               i2c_sda_i,
  output logic               i2c_scl_o,
  output logic               i2c_sda_o,
  output logic               i2c_scl_oe,
  output logic               i2c_sda_oe
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_STOP, S_XFER} state_t;

  state_t             state_q, state_d;
  logic [1:0]         qtr_q, qtr_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               first_q, first_d;
  logic [3:0]         bit_q, bit_d;
  logic [7:0]         sh_q, sh_d;
  logic               rd_q, rd_d;
  logic               nack_q, nack_d;
  logic               ack_q, ack_d;
  logic               scl_oe_q, scl_oe_d;
  logic               sda_oe_q, sda_oe_d;
  logic               done_q, done_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rx_nack_q, rx_nack_d;
  logic               arb_q, arb_d;
  logic               busy_q, busy_d;

  logic stall, qend, sample, arb_hit;

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    cnt_d     = cnt_q;
    first_d   = 1'b0;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rd_d      = rd_q;
    nack_d    = nack_q;
    ack_d     = ack_q;
    scl_oe_d  = scl_oe_q;
    sda_oe_d  = sda_oe_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    rx_nack_d = rx_nack_q;
    arb_d     = arb_q;
    busy_d    = busy_q;

    // A slave holding SCL low while we release it freezes the quarter timer.
    stall   = !scl_oe_q && !i2c_scl_i;
    qend    = !stall && (cnt_q == '0);
    sample  = (qtr_q == 2'd3) && first_q;
    arb_hit = 1'b0;

    if (state_q != S_IDLE && !stall) begin
      if (cnt_q == '0) begin
        cnt_d   = presc;
        qtr_d   = qtr_q + 2'd1;
        first_d = 1'b1;
      end else begin
        cnt_d = cnt_q - PRESC_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cnt_d   = presc;
          qtr_d   = 2'd0;
          first_d = 1'b1;
          bit_d   = 4'd0;
          sh_d    = cmd_wdata;
          rd_d    = cmd[0];
          nack_d  = cmd_nack;
          case (cmd)
            2'b00: begin state_d = S_START; sda_oe_d = 1'b0; end
            2'b01: begin state_d = S_STOP;  sda_oe_d = 1'b1; end
            default: begin
              state_d  = S_XFER;
              scl_oe_d = 1'b1;
              sda_oe_d = cmd[0] ? 1'b0 : ~cmd_wdata[7];
            end
          endcase
        end
      end
      S_START: begin
        if (qend) begin
          case (qtr_q)
            2'd0: scl_oe_d = 1'b0;
            2'd1: sda_oe_d = 1'b1;
            2'd2: scl_oe_d = 1'b1;
            2'd3: begin
              state_d = S_IDLE;
              busy_d  = 1'b1;
              arb_d   = 1'b0;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      S_STOP: begin
        if (qend) begin
          case (qtr_q)
            2'd0: scl_oe_d = 1'b0;
            2'd1: sda_oe_d = 1'b0;
            2'd2: ;
            2'd3: begin
              state_d  = S_IDLE;
              busy_d   = 1'b0;
              scl_oe_d = 1'b0;
              sda_oe_d = 1'b0;
              done_d   = 1'b1;
            end
          endcase
        end
      end
      S_XFER: begin
        if (sample) begin
          if (bit_q < 4'd8) sh_d = {sh_q[6:0], i2c_sda_i};
          else              ack_d = i2c_sda_i;
          arb_hit = !rd_q && (bit_q < 4'd8) && !sda_oe_q && !i2c_sda_i;
        end
        if (qend) begin
          case (qtr_q)
            2'd0: ;
            2'd1: scl_oe_d = 1'b0;
            2'd2: ;
            2'd3: begin
              if (bit_q == 4'd8) begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                scl_oe_d = 1'b1;
                sda_oe_d = 1'b0;
                if (rd_q) rdata_d   = sh_q;
                else      rx_nack_d = ack_d;
              end else begin
                bit_d    = bit_q + 4'd1;
                scl_oe_d = 1'b1;
                // sh_d[7] already holds the next data bit after this bit's shift.
                if (bit_q == 4'd7) sda_oe_d = rd_q ? ~nack_q : 1'b0;
                else               sda_oe_d = rd_q ? 1'b0 : ~sh_d[7];
              end
            end
          endcase
        end
        if (arb_hit) begin
          state_d  = S_IDLE;
          arb_d    = 1'b1;
          busy_d   = 1'b0;
          scl_oe_d = 1'b0;
          sda_oe_d = 1'b0;
          done_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      qtr_q     <= 2'd0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      bit_q     <= 4'd0;
      sh_q      <= 8'h00;
      rd_q      <= 1'b0;
      nack_q    <= 1'b0;
      ack_q     <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= 8'h00;
      rx_nack_q <= 1'b0;
      arb_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      rd_q      <= rd_d;
      nack_q    <= nack_d;
      ack_q     <= ack_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      rx_nack_q <= rx_nack_d;
      arb_q     <= arb_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign rx_nack    = rx_nack_q;
  assign arb_lost   = arb_q;
  assign busy       = busy_q;
  assign i2c_scl_o  = 1'b0;
  assign i2c_sda_o  = 1'b0;
  assign i2c_scl_oe = scl_oe_q;
  assign i2c_sda_oe = sda_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_i2cm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2cm_ctrl
//  Purpose  : Directed self-checking bench for i2cm_ctrl with a simple
//             open-drain bus and scripted slave.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2cm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] presc = 16'd0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd = 2'b00;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        cmd_nack = 1'b0;
  logic        done;
  logic [7:0]  rdata;
  logic        rx_nack, arb_lost, busy;
  logic        i2c_scl_i, i2c_sda_i, i2c_scl_o, i2c_sda_o, i2c_scl_oe, i2c_sda_oe;

  logic slave_sda = 1'b1;
  logic slave_scl_low = 1'b0;

  assign i2c_scl_i = ~i2c_scl_oe & ~slave_scl_low;
  assign i2c_sda_i = ~i2c_sda_oe & slave_sda;

  always #5 clk = ~clk;

  i2cm_ctrl #(.PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .presc(presc),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .cmd_wdata(cmd_wdata), .cmd_nack(cmd_nack),
    .done(done), .rdata(rdata), .rx_nack(rx_nack), .arb_lost(arb_lost), .busy(busy),
    .i2c_scl_i(i2c_scl_i), .i2c_sda_i(i2c_sda_i),
    .i2c_scl_o(i2c_scl_o), .i2c_sda_o(i2c_sda_o),
    .i2c_scl_oe(i2c_scl_oe), .i2c_sda_oe(i2c_sda_oe)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic sda_hist [0:63];
  logic scl_hist [0:63];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command and follow it to done. pat[8-b] is the slave SDA level for
  // bit b (1 = released); obs[8-b] records sda_oe early in bit b.
  task automatic do_cmd(input logic [1:0] c, input logic [7:0] wd, input logic nk,
                        input int pr, input logic [8:0] pat,
                        input int st_at, input int st_len, input int rst_at,
                        output int lat, output logic [8:0] obs);
    int q;
    int b;
    q = pr + 1;
    presc = pr[15:0]; cmd = c; cmd_wdata = wd; cmd_nack = nk; cmd_valid = 1'b1;
    obs = '0; lat = -1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = ~c; cmd_wdata = ~wd; cmd_nack = ~nk;
    for (int cyc = 1; cyc < 4000; cyc++) begin
      b = (cyc - 1) / (4 * q);
      slave_sda = (c[1] && b < 9) ? pat[8 - b] : 1'b1;
      slave_scl_low = (st_len > 0 && cyc >= st_at && cyc < st_at + st_len);
      if (cyc < 64) begin
        sda_hist[cyc] = i2c_sda_oe;
        scl_hist[cyc] = i2c_scl_oe;
      end
      if (c[1] && b < 9 && ((cyc - 1) % (4 * q)) == 1) obs[8 - b] = i2c_sda_oe;
      if (rst_at > 0 && cyc == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lat = 0;
        break;
      end
      if (done) begin
        lat = cyc;
        chk("ready_at_done", {31'd0, cmd_ready}, 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    slave_sda = 1'b1;
    slave_scl_low = 1'b0;
    if (lat < 0) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int done_cnt;
    logic [8:0] obs;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl_oe", {31'd0, i2c_scl_oe}, 32'd0);
    chk("rst_sda_oe", {31'd0, i2c_sda_oe}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_rdata",  {24'd0, rdata}, 32'd0);
    chk("rst_flags",  {28'd0, rx_nack, arb_lost, busy, cmd_ready}, 32'd1);
    chk("rst_o",      {30'd0, i2c_scl_o, i2c_sda_o}, 32'd0);
    rst = 1'b0;

    // START, Q=1
    do_cmd(2'b00, 8'h00, 1'b0, 0, 9'h1FF, 0, 0, 0, lat, obs);
    chk("start_lat", lat, 32'd5);
    chk("start_sda_c2", {31'd0, sda_hist[2]}, 32'd0);
    chk("start_sda_c3", {31'd0, sda_hist[3]}, 32'd1);
    chk("start_scl_c3", {31'd0, scl_hist[3]}, 32'd0);
    chk("start_scl_c4", {31'd0, scl_hist[4]}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // WRITE 0xA5, Q=2, slave acks
    do_cmd(2'b10, 8'hA5, 1'b0, 1, 9'h1FE, 0, 0, 0, lat, obs);
    chk("wr_lat", lat, 32'd73);
    chk("wr_sda_pattern", {23'd0, obs}, 32'h0B4);
    chk("wr_rx_nack", {31'd0, rx_nack}, 32'd0);
    chk("wr_end_oe", {30'd0, i2c_scl_oe, i2c_sda_oe}, 32'd2);

    // READ 0x3C with NACK, Q=1
    do_cmd(2'b11, 8'h00, 1'b1, 0, {8'h3C, 1'b1}, 0, 0, 0, lat, obs);
    chk("rd1_lat", lat, 32'd37);
    chk("rd1_rdata", {24'd0, rdata}, 32'h3C);
    chk("rd1_sda_oe", {23'd0, obs}, 32'h000);
    chk("rd1_rx_nack", {31'd0, rx_nack}, 32'd0);

    // READ 0x81 with ACK, Q=3
    do_cmd(2'b11, 8'h00, 1'b0, 2, {8'h81, 1'b1}, 0, 0, 0, lat, obs);
    chk("rd2_lat", lat, 32'd109);
    chk("rd2_rdata", {24'd0, rdata}, 32'h81);
    chk("rd2_sda_oe", {23'd0, obs}, 32'h001);

    // WRITE 0x55, Q=1, SCL stretched 10 cycles in bit 3 q2, slave NACKs
    do_cmd(2'b10, 8'h55, 1'b0, 0, 9'h1FF, 15, 10, 0, lat, obs);
    chk("stretch_lat", lat, 32'd47);
    chk("stretch_rx_nack", {31'd0, rx_nack}, 32'd1);
    chk("stretch_rdata_kept", {24'd0, rdata}, 32'h81);

    // STOP, Q=1
    do_cmd(2'b01, 8'h00, 1'b0, 0, 9'h1FF, 0, 0, 0, lat, obs);
    chk("stop_lat", lat, 32'd5);
    chk("stop_q0", {30'd0, scl_hist[1], sda_hist[1]}, 32'd3);
    chk("stop_q1_scl", {31'd0, scl_hist[2]}, 32'd0);
    chk("stop_q2_sda", {31'd0, sda_hist[3]}, 32'd0);
    chk("stop_end", {29'd0, busy, i2c_scl_oe, i2c_sda_oe}, 32'd0);

    // Arbitration loss on bit 2 of WRITE 0xFF
    do_cmd(2'b00, 8'h00, 1'b0, 0, 9'h1FF, 0, 0, 0, lat, obs);
    do_cmd(2'b10, 8'hFF, 1'b0, 0, 9'h1BF, 0, 0, 0, lat, obs);
    chk("arb_lost", {31'd0, arb_lost}, 32'd1);
    chk("arb_lines", {30'd0, i2c_scl_oe, i2c_sda_oe}, 32'd0);
    chk("arb_busy", {31'd0, busy}, 32'd0);
    do_cmd(2'b00, 8'h00, 1'b0, 0, 9'h1FF, 0, 0, 0, lat, obs);
    chk("arb_cleared", {30'd0, arb_lost, busy}, 32'd1);

    // Reset during bit 4 of a WRITE
    do_cmd(2'b10, 8'h00, 1'b0, 0, 9'h1FF, 0, 0, 18, lat, obs);
    chk("rst_mid_lines", {30'd0, i2c_scl_oe, i2c_sda_oe}, 32'd0);
    chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    chk("rst_mid_no_done", done_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
